secuenciador_prueba_motores: RTL and testbench

//  Synthesizable, parametrised stimulus sequencer for the motor-controller DUT.
//  On INICIAR it runs DUT reset -> settle -> run (ARRANQUE + per-channel MODO) for N_MOTORES channels.

---
 rtl/secuenciador_prueba_motores_pkg.sv | 24 ++
 rtl/secuenciador_prueba_motores_contador_saturado.sv | 27 ++
 rtl/secuenciador_prueba_motores.sv | 116 +++++++++++
 tb/tb_secuenciador_prueba_motores.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/secuenciador_prueba_motores_pkg.sv
// Shared types and default phase lengths for the motor-test stimulus sequencer.
// State encoding is visible here so checkers can decode the debug state output.
package secuenciador_prueba_motores_pkg;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_RST_DUT = 3'd1,
        S_ESPERA  = 3'd2,
        S_CORRIDA = 3'd3,
        S_FIN     = 3'd4
    } estado_t;

    localparam int DEF_N_MOTORES      = 2;
    localparam int DEF_CICLOS_RESET   = 2;
    localparam int DEF_CICLOS_ESPERA  = 1;
    localparam int DEF_CICLOS_CORRIDA = 100;
    localparam int DEF_ANCHO_CNT      = 8;

    // A phase of N cycles needs to reach N-1 in an ANCHO-bit counter.
    function automatic bit fase_valida(input int ciclos, input int ancho);
        return (ciclos >= 1) && ((ancho >= 31) || (ciclos <= (1 << ancho)));
    endfunction

endpackage

// File: rtl/secuenciador_prueba_motores_contador_saturado.sv
// Per-channel active-cycle counter: synchronous clear wins over enable,
// and the count sticks at all-ones instead of wrapping.
module contador_saturado #(
    parameter int ANCHO = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             clr,
    output logic [ANCHO-1:0] q
);

    logic [ANCHO-1:0] r_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_q <= '0;
        end else if (clr) begin
            r_q <= '0;
        end else if (en && (r_q != '1)) begin
            r_q <= r_q + 1'b1;
        end
    end

    assign q = r_q;

endmodule

// File: rtl/secuenciador_prueba_motores.sv
// Stimulus sequencer for the motor-controller DUT: reset -> settle -> run,
// counting per-channel motor activity and flagging activity seen before start.
module secuenciador_prueba_motores
    import secuenciador_prueba_motores_pkg::*;
#(
    parameter int N_MOTORES      = DEF_N_MOTORES,
    parameter int CICLOS_RESET   = DEF_CICLOS_RESET,
    parameter int CICLOS_ESPERA  = DEF_CICLOS_ESPERA,
    parameter int CICLOS_CORRIDA = DEF_CICLOS_CORRIDA,
    parameter int ANCHO_CNT      = DEF_ANCHO_CNT
) (
    input  logic                           CLK,
    input  logic                           REINICIO,
    input  logic                           INICIAR,
    input  logic [N_MOTORES-1:0]           MODO_CFG,
    input  logic [N_MOTORES-1:0]           MOTOR,
    output logic                           REINICIO_DUT,
    output logic                           ARRANQUE,
    output logic [N_MOTORES-1:0]           MODO,
    output logic                           OCUPADO,
    output logic                           TERMINADO,
    output logic                           ERROR,
    output logic [N_MOTORES*ANCHO_CNT-1:0] CICLOS_ON,
    output estado_t                        ESTADO_DBG
);

    if ((N_MOTORES < 1) || (ANCHO_CNT < 1) ||
        !fase_valida(CICLOS_RESET, ANCHO_CNT) ||
        !fase_valida(CICLOS_ESPERA, ANCHO_CNT) ||
        !fase_valida(CICLOS_CORRIDA, ANCHO_CNT)) begin : g_parametros_invalidos
        $error("secuenciador_prueba_motores: phase length or width out of range");
    end

    localparam logic [ANCHO_CNT-1:0] L_ULT_RESET   = ANCHO_CNT'(CICLOS_RESET - 1);
    localparam logic [ANCHO_CNT-1:0] L_ULT_ESPERA  = ANCHO_CNT'(CICLOS_ESPERA - 1);
    localparam logic [ANCHO_CNT-1:0] L_ULT_CORRIDA = ANCHO_CNT'(CICLOS_CORRIDA - 1);

    estado_t                r_estado;
    estado_t                w_estado_sig;
    logic [ANCHO_CNT-1:0]   r_cnt_fase;
    logic [N_MOTORES-1:0]   r_modo;
    logic                   r_reinicio_dut;
    logic                   r_arranque;
    logic                   r_ocupado;
    logic                   r_terminado;
    logic                   r_error;
    logic                   w_aceptar;
    logic                   w_pre_arranque;
    logic [N_MOTORES-1:0]   w_cuenta_en;

    always_comb begin
        w_estado_sig = r_estado;
        case (r_estado)
            S_IDLE:    if (INICIAR) w_estado_sig = S_RST_DUT;
            S_RST_DUT: if (r_cnt_fase == L_ULT_RESET) w_estado_sig = S_ESPERA;
            S_ESPERA:  if (r_cnt_fase == L_ULT_ESPERA) w_estado_sig = S_CORRIDA;
            S_CORRIDA: if (r_cnt_fase == L_ULT_CORRIDA) w_estado_sig = S_FIN;
            S_FIN:     w_estado_sig = S_IDLE;
            default:   w_estado_sig = S_IDLE;
        endcase
    end

    assign w_aceptar      = (r_estado == S_IDLE) && INICIAR;
    assign w_pre_arranque = (r_estado == S_RST_DUT) || (r_estado == S_ESPERA);
    assign w_cuenta_en    = (r_estado == S_CORRIDA) ? MOTOR : '0;

    // Outputs are registered from the next state so they line up with the state itself.
    always_ff @(posedge CLK or negedge REINICIO) begin
        if (!REINICIO) begin
            r_estado       <= S_IDLE;
            r_cnt_fase     <= '0;
            r_modo         <= '0;
            r_reinicio_dut <= 1'b0;
            r_arranque     <= 1'b0;
            r_ocupado      <= 1'b0;
            r_terminado    <= 1'b0;
            r_error        <= 1'b0;
        end else begin
            r_estado       <= w_estado_sig;
            r_cnt_fase     <= (w_estado_sig != r_estado) ? '0 : r_cnt_fase + 1'b1;
            r_reinicio_dut <= (w_estado_sig == S_RST_DUT);
            r_arranque     <= (w_estado_sig == S_CORRIDA);
            r_ocupado      <= (w_estado_sig != S_IDLE);
            r_terminado    <= (w_estado_sig == S_FIN);
            if (w_aceptar) begin
                r_modo <= MODO_CFG;
            end
            if (w_aceptar) begin
                r_error <= 1'b0;
            end else if (w_pre_arranque && (|MOTOR)) begin
                r_error <= 1'b1;
            end
        end
    end

    for (genvar g = 0; g < N_MOTORES; g++) begin : g_canal
        contador_saturado #(
            .ANCHO (ANCHO_CNT)
        ) u_contador (
            .clk   (CLK),
            .rst_n (REINICIO),
            .en    (w_cuenta_en[g]),
            .clr   (w_aceptar),
            .q     (CICLOS_ON[g*ANCHO_CNT +: ANCHO_CNT])
        );
    end

    assign REINICIO_DUT = r_reinicio_dut;
    assign ARRANQUE     = r_arranque;
    assign MODO         = r_modo;
    assign OCUPADO      = r_ocupado;
    assign TERMINADO    = r_terminado;
    assign ERROR        = r_error;
    assign ESTADO_DBG   = r_estado;

endmodule

// File: tb/tb_secuenciador_prueba_motores.sv
// Bench for the motor-test sequencer: a default-parameter instance (A) and a
// narrow 4-channel instance (B) for saturation and back-to-back runs.
module tb_secuenciador_prueba_motores;
  import secuenciador_prueba_motores_pkg::*;

  localparam int NA = 2, AA = 8, RA = 2, EA = 1, CA = 100;
  localparam int FIN_A = RA + EA + CA + 1;
  localparam int NB = 4, AB = 4, RB = 2, EB = 1, CB = 16;
  localparam int FIN_B = RB + EB + CB + 1;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              rst_a_n, iniciar_a;
  logic [NA-1:0]     modo_cfg_a, motor_a, modo_a;
  logic              reinicio_dut_a, arranque_a, ocupado_a, terminado_a, error_a;
  logic [NA*AA-1:0]  ciclos_on_a;
  estado_t           estado_a;

  logic              rst_b_n, iniciar_b;
  logic [NB-1:0]     modo_cfg_b, motor_b, modo_b;
  logic              reinicio_dut_b, arranque_b, ocupado_b, terminado_b, error_b;
  logic [NB*AB-1:0]  ciclos_on_b;
  estado_t           estado_b;

  secuenciador_prueba_motores u_dut_a (
    .CLK(clk), .REINICIO(rst_a_n), .INICIAR(iniciar_a), .MODO_CFG(modo_cfg_a), .MOTOR(motor_a),
    .REINICIO_DUT(reinicio_dut_a), .ARRANQUE(arranque_a), .MODO(modo_a), .OCUPADO(ocupado_a),
    .TERMINADO(terminado_a), .ERROR(error_a), .CICLOS_ON(ciclos_on_a), .ESTADO_DBG(estado_a)
  );

  secuenciador_prueba_motores #(
    .N_MOTORES(NB), .CICLOS_RESET(RB), .CICLOS_ESPERA(EB), .CICLOS_CORRIDA(CB), .ANCHO_CNT(AB)
  ) u_dut_b (
    .CLK(clk), .REINICIO(rst_b_n), .INICIAR(iniciar_b), .MODO_CFG(modo_cfg_b), .MOTOR(motor_b),
    .REINICIO_DUT(reinicio_dut_b), .ARRANQUE(arranque_b), .MODO(modo_b), .OCUPADO(ocupado_b),
    .TERMINADO(terminado_b), .ERROR(error_b), .CICLOS_ON(ciclos_on_b), .ESTADO_DBG(estado_b)
  );

  // ---------------- checking ----------------
  int n_checks = 0;
  int n_fail = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s observed=0x%0h expected=0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // ---------------- scoreboards ----------------
  // A entry: {error, modo[1:0], ciclos_on[15:0], arranque_cycles[7:0], reinicio_cycles[7:0]}
  logic [34:0] exp_a_q[$];
  // B entry: {modo[3:0], ciclos_on[15:0], arranque_cycles[7:0], reinicio_cycles[7:0]}
  logic [35:0] exp_b_q[$];
  logic [34:0] e_a;
  logic [35:0] e_b;
  int arr_a = 0, rcy_a = 0, arr_b = 0, rcy_b = 0;

  always @(posedge clk) begin
    #1;
    if (!rst_a_n) begin
      arr_a = 0;
      rcy_a = 0;
    end else begin
      if (arranque_a) arr_a++;
      if (reinicio_dut_a) rcy_a++;
      if (terminado_a) begin
        if (exp_a_q.size() == 0) begin
          check("a_terminado_unexpected", 64'(1), 64'(0));
        end else begin
          e_a = exp_a_q.pop_front();
          check("a_sb_error", 64'(error_a), 64'(e_a[34]));
          check("a_sb_modo", 64'(modo_a), 64'(e_a[33:32]));
          check("a_sb_ciclos_on", 64'(ciclos_on_a), 64'(e_a[31:16]));
          check("a_sb_arranque_len", 64'(arr_a), 64'(e_a[15:8]));
          check("a_sb_reinicio_len", 64'(rcy_a), 64'(e_a[7:0]));
        end
        arr_a = 0;
        rcy_a = 0;
      end
    end
  end

  always @(posedge clk) begin
    #1;
    if (!rst_b_n) begin
      arr_b = 0;
      rcy_b = 0;
    end else begin
      if (arranque_b) arr_b++;
      if (reinicio_dut_b) rcy_b++;
      if (terminado_b) begin
        if (exp_b_q.size() == 0) begin
          check("b_terminado_unexpected", 64'(1), 64'(0));
        end else begin
          e_b = exp_b_q.pop_front();
          check("b_sb_modo", 64'(modo_b), 64'(e_b[35:32]));
          check("b_sb_ciclos_on", 64'(ciclos_on_b), 64'(e_b[31:16]));
          check("b_sb_arranque_len", 64'(arr_b), 64'(e_b[15:8]));
          check("b_sb_reinicio_len", 64'(rcy_b), 64'(e_b[7:0]));
        end
        arr_b = 0;
        rcy_b = 0;
      end
    end
  end

  // ---------------- driver tasks ----------------
  // Cycle c counts from the first cycle after the accepting edge:
  // 1..R reset, R+1..R+E settle, R+E+1..R+E+C run, R+E+C+1 finish.
  task automatic run_a(input logic [1:0] modo, input bit rnd, input logic [1:0] pat,
                       input int err_cyc, input int extra_cyc, input int abort_cyc);
    int cnt[NA];
    logic [NA*AA-1:0] exp_on;
    bit exp_err;
    foreach (cnt[i]) cnt[i] = 0;
    modo_cfg_a = modo;
    iniciar_a = 1'b1;
    motor_a = '0;
    @(negedge clk);
    for (int c = 1; c <= FIN_A; c++) begin
      exp_err = (err_cyc != 0) && (c > err_cyc);
      if (c == abort_cyc) begin
        rst_a_n = 1'b0;
        #1;
        check("a_abort_reinicio_dut", 64'(reinicio_dut_a), 64'(0));
        check("a_abort_arranque", 64'(arranque_a), 64'(0));
        check("a_abort_modo", 64'(modo_a), 64'(0));
        check("a_abort_ocupado", 64'(ocupado_a), 64'(0));
        check("a_abort_terminado", 64'(terminado_a), 64'(0));
        check("a_abort_error", 64'(error_a), 64'(0));
        check("a_abort_ciclos_on", 64'(ciclos_on_a), 64'(0));
        @(negedge clk);
        rst_a_n = 1'b1;
        iniciar_a = 1'b0;
        motor_a = '0;
        return;
      end
      check("a_reinicio_dut", 64'(reinicio_dut_a), 64'(c <= RA));
      check("a_arranque", 64'(arranque_a), 64'((c > RA + EA) && (c <= RA + EA + CA)));
      check("a_ocupado", 64'(ocupado_a), 64'(1));
      check("a_terminado", 64'(terminado_a), 64'(c == FIN_A));
      check("a_modo", 64'(modo_a), 64'(modo));
      check("a_error", 64'(error_a), 64'(exp_err));
      if (c <= RA + EA + 1) check("a_ciclos_on_cleared", 64'(ciclos_on_a), 64'(0));
      iniciar_a = (c == extra_cyc);
      modo_cfg_a = 2'($urandom_range(0, 3));
      if ((c > RA + EA) && (c <= RA + EA + CA)) begin
        motor_a = rnd ? 2'($urandom_range(0, 3)) : pat;
        for (int i = 0; i < NA; i++) if (motor_a[i] && (cnt[i] < 255)) cnt[i]++;
      end else if (c == err_cyc) begin
        motor_a = 2'b10;
      end else if (c == FIN_A) begin
        motor_a = 2'($urandom_range(0, 3));
      end else begin
        motor_a = '0;
      end
      if (c == RA + EA + CA) begin
        for (int i = 0; i < NA; i++) exp_on[i*AA +: AA] = AA'(cnt[i]);
        exp_a_q.push_back({(err_cyc != 0), modo, exp_on, 8'(CA), 8'(RA)});
      end
      @(negedge clk);
    end
    exp_err = (err_cyc != 0);
    for (int j = 0; j < 4; j++) begin
      check("a_idle_ocupado", 64'(ocupado_a), 64'(0));
      check("a_idle_terminado", 64'(terminado_a), 64'(0));
      check("a_idle_ciclos_on_held", 64'(ciclos_on_a), 64'(exp_on));
      check("a_idle_error_held", 64'(error_a), 64'(exp_err));
      check("a_idle_modo_held", 64'(modo_a), 64'(modo));
      motor_a = 2'($urandom_range(0, 3));
      @(negedge clk);
    end
    motor_a = '0;
  endtask

  // Caller leaves iniciar_b high and modo_cfg_b = modo; the next edge accepts.
  task automatic run_b(input logic [3:0] modo, input logic [3:0] modo_sig, input bit rnd);
    int cnt[NB];
    logic [NB*AB-1:0] exp_on;
    foreach (cnt[i]) cnt[i] = 0;
    motor_b = '0;
    @(negedge clk);
    for (int c = 1; c <= FIN_B; c++) begin
      check("b_reinicio_dut", 64'(reinicio_dut_b), 64'(c <= RB));
      check("b_arranque", 64'(arranque_b), 64'((c > RB + EB) && (c <= RB + EB + CB)));
      check("b_ocupado", 64'(ocupado_b), 64'(1));
      check("b_terminado", 64'(terminado_b), 64'(c == FIN_B));
      check("b_modo", 64'(modo_b), 64'(modo));
      check("b_error", 64'(error_b), 64'(0));
      if (c <= RB + EB + 1) check("b_ciclos_on_cleared", 64'(ciclos_on_b), 64'(0));
      if (c == 1) modo_cfg_b = modo_sig;
      if ((c > RB + EB) && (c <= RB + EB + CB)) begin
        motor_b = rnd ? 4'($urandom_range(0, 15)) : 4'hF;
        for (int i = 0; i < NB; i++) if (motor_b[i] && (cnt[i] < 15)) cnt[i]++;
      end else begin
        motor_b = '0;
      end
      if (c == RB + EB + CB) begin
        for (int i = 0; i < NB; i++) exp_on[i*AB +: AB] = AB'(cnt[i]);
        exp_b_q.push_back({modo, exp_on, 8'(CB), 8'(RB)});
      end
      @(negedge clk);
    end
    check("b_gap_ocupado", 64'(ocupado_b), 64'(0));
    check("b_gap_terminado", 64'(terminado_b), 64'(0));
    check("b_gap_ciclos_on", 64'(ciclos_on_b), 64'(exp_on));
  endtask

  // ---------------- main sequence ----------------
  initial begin
    rst_a_n = 1'b0; iniciar_a = 1'b0; modo_cfg_a = '0; motor_a = '0;
    rst_b_n = 1'b0; iniciar_b = 1'b0; modo_cfg_b = '0; motor_b = '0;
    repeat (3) @(negedge clk);
    check("a_rst_reinicio_dut", 64'(reinicio_dut_a), 64'(0));
    check("a_rst_arranque", 64'(arranque_a), 64'(0));
    check("a_rst_modo", 64'(modo_a), 64'(0));
    check("a_rst_ocupado", 64'(ocupado_a), 64'(0));
    check("a_rst_terminado", 64'(terminado_a), 64'(0));
    check("a_rst_error", 64'(error_a), 64'(0));
    check("a_rst_ciclos_on", 64'(ciclos_on_a), 64'(0));
    check("b_rst_ocupado", 64'(ocupado_b), 64'(0));
    check("b_rst_ciclos_on", 64'(ciclos_on_b), 64'(0));
    rst_a_n = 1'b1;
    rst_b_n = 1'b1;
    repeat (2) @(negedge clk);
    check("a_idle_no_start", 64'(ocupado_a), 64'(0));

    run_a(2'b01, 1'b0, 2'b01, 0, 0, 0);
    run_a(2'b10, 1'b1, 2'b00, RA + EA, 0, 0);
    run_a(2'b11, 1'b1, 2'b00, 0, RA + EA + 30, 0);
    run_a(2'b01, 1'b0, 2'b11, 0, 0, RA + EA + 50);
    for (int j = 0; j < 4; j++) begin
      check("a_post_abort_ocupado", 64'(ocupado_a), 64'(0));
      check("a_post_abort_terminado", 64'(terminado_a), 64'(0));
      check("a_post_abort_arranque", 64'(arranque_a), 64'(0));
      @(negedge clk);
    end
    run_a(2'b10, 1'b1, 2'b00, 1, 0, 0);

    modo_cfg_b = 4'b1010;
    iniciar_b = 1'b1;
    run_b(4'b1010, 4'b0110, 1'b0);
    run_b(4'b0110, 4'b0011, 1'b1);
    iniciar_b = 1'b0;
    repeat (2) @(negedge clk);
    check("b_stop_ocupado", 64'(ocupado_b), 64'(0));
    check("b_stop_modo_held", 64'(modo_b), 64'(4'b0110));

    check("a_queue_drained", 64'(exp_a_q.size()), 64'(0));
    check("b_queue_drained", 64'(exp_b_q.size()), 64'(0));
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
